vram_access_ctrl: RTL and testbench
===================================

VRAM_ACCESS_CTRL -- requirements
Module: vram_access_ctrl

Interface
REQ-001 SHALL have parameter AW, default 14, meaning VRAM address width.
REQ-002 SHALL have parameter DW, default 8, meaning data width.
REQ-003 SHALL have parameter PAL_BASE, default 14'h3F00, meaning first palette-range address; the range runs from here to the top of the address space.
REQ-004 SHALL have parameter INC_WIDE, default 32, meaning the wide auto-increment step.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-006 PCLK  in  1  sole clock; all state updates on the rising edge.
REQ-007 RES  in  1  synchronous active-high reset.
REQ-008 BLNK  in  1  1 = rendering off; CPU accesses are permitted.
REQ-009 R7  in  1  single-cycle CPU data-port read request.
REQ-010 W7  in  1  single-cycle CPU data-port write request.
REQ-011 CPU_DI  in  DW  write data, sampled with W7.
REQ-012 I_INC  in  1  increment select: 0 = +1, 1 = +INC_WIDE.
REQ-013 ADDR_LD / ADDR_IN  in  1 / AW  address load strobe and load value.
REQ-014 PD_IN  in  DW  VRAM read data.
REQ-015 PA  out  AW  VRAM address.
REQ-016 PD_OUT  out  DW  VRAM write data.
REQ-017 PD_OE  out  1  PD_OUT drive enable.
REQ-018 n_ALE  out  1  address latch enable, active low.
REQ-019 RD / WR  out  1 / 1  VRAM read / write strobes.
REQ-020 CPU_DO  out  DW  read result returned to the CPU.
REQ-021 CPU_DO_VLD  out  1  one-cycle pulse marking CPU_DO valid.
REQ-022 BUSY  out  1  access in progress or request pending.
REQ-023 DROP  out  1  one-cycle pulse when a request is discarded.

Function
REQ-024 FSM states SHALL be IDLE, ALE, STROBE, DONE; each access SHALL take exactly 3 cycles (ALE -> STROBE -> DONE), then return to IDLE, or go straight to ALE if a request is pending.
REQ-025 IDLE -> ALE SHALL occur when a request is present (new or pending) and BLNK=1; with BLNK=0 the request SHALL wait, holding BUSY=1.
REQ-026 ALE SHALL drive n_ALE=0 and latch the current address onto PA; PA SHALL hold that value through STROBE and DONE.
REQ-027 STROBE SHALL assert RD=1 for a read, or WR=1 and PD_OE=1 for a write, with PD_OUT carrying the latched CPU_DI.
REQ-028 DONE on a read SHALL load PD_IN into the read buffer.
REQ-029 DONE SHALL advance the address by 1 (I_INC=0) or INC_WIDE (I_INC=1), using I_INC as sampled at request time and wrapping modulo 2^AW.
REQ-030 For a non-palette read (address < PAL_BASE), CPU_DO SHALL equal the old buffer contents, with CPU_DO_VLD pulsed the cycle after R7.
REQ-031 For a palette read (address >= PAL_BASE), CPU_DO SHALL equal the fetched PD_IN, with CPU_DO_VLD pulsed in the cycle after DONE.
REQ-032 Queue depth SHALL be one pending request; a request arriving while the slot is occupied SHALL be discarded with DROP=1.
REQ-033 R7 and W7 asserted in the same cycle SHALL cause W7 to be taken, R7 to be discarded, and DROP=1.
REQ-034 ADDR_LD SHALL take effect next cycle and override a same-cycle DONE increment; the in-flight PA SHALL be unaffected.
REQ-035 Outside their stated states, n_ALE SHALL be 1 and RD, WR and PD_OE SHALL be 0; RD and WR SHALL never both be 1.

Reset
REQ-036 RES=1 SHALL force state IDLE, address 0, buffer 0, pending slot empty, PA=0, n_ALE=1, and RD, WR, PD_OE, CPU_DO, CPU_DO_VLD, BUSY and DROP all 0.
REQ-037 RES mid-access SHALL abort the access, with no increment, no buffer load and no CPU_DO_VLD.

Structure
REQ-038 Shared package vram_access_pkg SHALL hold the FSM state enum and the parameter defaults.
REQ-039 The address register plus incrementer SHALL form sub-module vram_addr_counter.

Verification
REQ-040 ADDR_LD 0x2000, then BLNK=1 and W7 with 0x5A, I_INC=0 -> n_ALE low at cycle 1, WR at cycle 2 with PA=0x2000 and PD_OUT=0x5A, address becomes 0x2001.
REQ-041 Two R7s at 0x2400 (PD_IN 0x11, then 0x22) -> first CPU_DO=0x00, second CPU_DO=0x11.
REQ-042 R7 at 0x3F05 with PD_IN=0x0C -> CPU_DO=0x0C, with CPU_DO_VLD in the cycle after DONE.
REQ-043 Address 0x3FE8 with I_INC=1 and W7 -> address wraps to 0x0008.
REQ-044 Three back-to-back W7s while BUSY -> second access queued, third gives DROP=1, exactly two WR pulses.
REQ-045 RES during STROBE -> all outputs at reset values next cycle, address 0.

Source files
------------

// File: rtl/vram_access_ctrl_pkg.sv
// Shared definitions for the VRAM access controller: parameter defaults and FSM state type.
package vram_access_pkg;

  localparam int unsigned AW_DEF       = 14;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned PAL_BASE_DEF = 32'h3F00;
  localparam int unsigned INC_WIDE_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALE,
    S_STROBE,
    S_DONE
  } vram_state_e;

endpackage

// File: rtl/vram_access_ctrl_if.sv
// CPU data-port and VRAM bus signals of the access controller, grouped as one interface.
interface vram_access_ctrl_if
  import vram_access_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  logic          BLNK;
  logic          R7;
  logic          W7;
  logic [DW-1:0] CPU_DI;
  logic          I_INC;
  logic          ADDR_LD;
  logic [AW-1:0] ADDR_IN;
  logic [DW-1:0] PD_IN;
  logic [AW-1:0] PA;
  logic [DW-1:0] PD_OUT;
  logic          PD_OE;
  logic          n_ALE;
  logic          RD;
  logic          WR;
  logic [DW-1:0] CPU_DO;
  logic          CPU_DO_VLD;
  logic          BUSY;
  logic          DROP;

  modport master (
    output BLNK, R7, W7, CPU_DI, I_INC, ADDR_LD, ADDR_IN, PD_IN,
    input  PA, PD_OUT, PD_OE, n_ALE, RD, WR, CPU_DO, CPU_DO_VLD, BUSY, DROP
  );

  modport slave (
    input  BLNK, R7, W7, CPU_DI, I_INC, ADDR_LD, ADDR_IN, PD_IN,
    output PA, PD_OUT, PD_OE, n_ALE, RD, WR, CPU_DO, CPU_DO_VLD, BUSY, DROP
  );

endinterface

// File: rtl/vram_access_ctrl_addr_counter.sv
// VRAM address register with load and +1 / +INC_WIDE auto-increment, wrapping modulo 2^AW.
module vram_addr_counter
  import vram_access_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned INC_WIDE = INC_WIDE_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ld_i,
  input  logic [AW-1:0] ld_val_i,
  input  logic          inc_en_i,
  input  logic          wide_i,
  output logic [AW-1:0] addr_next_o
);

  localparam logic [AW-1:0] STEP_ONE  = AW'(1);
  localparam logic [AW-1:0] STEP_WIDE = AW'(INC_WIDE);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  // A load wins over a same-cycle increment.
  always_comb begin
    addr_d = addr_q;
    if (ld_i) begin
      addr_d = ld_val_i;
    end else if (inc_en_i) begin
      addr_d = addr_q + (wide_i ? STEP_WIDE : STEP_ONE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_next_o = addr_d;

endmodule

// File: rtl/vram_access_ctrl.sv
// CPU-to-VRAM data-port sequencer: ALE -> STROBE -> DONE per access, one pending slot,
// buffered reads below the palette range and direct reads inside it.
module vram_access_ctrl
  import vram_access_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned PAL_BASE = PAL_BASE_DEF,
  parameter int unsigned INC_WIDE = INC_WIDE_DEF
) (
  input logic               PCLK,
  input logic               RES,
  vram_access_ctrl_if.slave bus
);

  localparam logic [AW-1:0] PAL_LO = AW'(PAL_BASE);

  typedef struct packed {
    logic          wr;
    logic          inc;
    logic          pal;
    logic [DW-1:0] data;
  } req_t;

  vram_state_e   state_q;
  req_t          cur_q;
  req_t          slot_q;
  logic          slot_vld_q;
  logic          slot_vld_d;
  req_t          new_req;
  req_t          launch_req;
  logic          new_vld;
  logic          new_acc;
  logic          launch;
  logic          drop;
  logic          imm_rsp;
  logic          in_done;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] pa_q;
  logic [DW-1:0] buf_q;
  logic [DW-1:0] pd_out_q;
  logic [DW-1:0] cpu_do_q;
  logic          n_ale_q;
  logic          rd_q;
  logic          wr_q;
  logic          pd_oe_q;
  logic          vld_q;
  logic          busy_q;
  logic          drop_q;

  assign in_done = (state_q == S_DONE);

  vram_addr_counter #(
    .AW       (AW),
    .INC_WIDE (INC_WIDE)
  ) u_addr (
    .clk_i       (PCLK),
    .rst_i       (RES),
    .ld_i        (bus.ADDR_LD),
    .ld_val_i    (bus.ADDR_IN),
    .inc_en_i    (in_done),
    .wide_i      (cur_q.inc),
    .addr_next_o (addr_d)
  );

  // A new request is accepted only into an empty slot; a pending request is always
  // served first, so anything arriving while the slot is full is dropped.
  // Palette classification uses the address the access will see next cycle.
  always_comb begin
    new_vld    = bus.W7 | bus.R7;
    new_req    = '{wr: bus.W7, inc: bus.I_INC, pal: (addr_d >= PAL_LO), data: bus.CPU_DI};
    new_acc    = new_vld & ~slot_vld_q;
    drop       = (bus.W7 & bus.R7) | (new_vld & slot_vld_q);
    launch     = ((state_q == S_IDLE) | in_done) & bus.BLNK & (slot_vld_q | new_vld);
    launch_req = slot_vld_q ? slot_q : new_req;
    imm_rsp    = new_acc & ~bus.W7 & ~new_req.pal;
    slot_vld_d = slot_vld_q;
    if (launch) begin
      slot_vld_d = 1'b0;
    end else if (new_acc) begin
      slot_vld_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (RES) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      pa_q       <= '0;
      buf_q      <= '0;
      pd_out_q   <= '0;
      cpu_do_q   <= '0;
      n_ale_q    <= 1'b1;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      pd_oe_q    <= 1'b0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      n_ale_q    <= 1'b1;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      pd_oe_q    <= 1'b0;
      vld_q      <= 1'b0;
      drop_q     <= drop;
      slot_vld_q <= slot_vld_d;
      busy_q     <= launch | (state_q == S_ALE) | (state_q == S_STROBE) | slot_vld_d;
      if (!launch && new_acc) begin
        slot_q <= new_req;
      end

      unique case (state_q)
        S_ALE: begin
          state_q  <= S_STROBE;
          rd_q     <= ~cur_q.wr;
          wr_q     <= cur_q.wr;
          pd_oe_q  <= cur_q.wr;
          pd_out_q <= cur_q.data;
        end
        S_STROBE: begin
          state_q <= S_DONE;
        end
        default: begin
          if (launch) begin
            state_q <= S_ALE;
            cur_q   <= launch_req;
            n_ale_q <= 1'b0;
            pa_q    <= addr_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase

      if (imm_rsp) begin
        cpu_do_q <= buf_q;
        vld_q    <= 1'b1;
      end
      // A completing palette read takes the CPU_DO port over a same-cycle buffered read.
      if (in_done && !cur_q.wr) begin
        buf_q <= bus.PD_IN;
        if (cur_q.pal) begin
          cpu_do_q <= bus.PD_IN;
          vld_q    <= 1'b1;
        end
      end
    end
  end

  assign bus.PA         = pa_q;
  assign bus.PD_OUT     = pd_out_q;
  assign bus.PD_OE      = pd_oe_q;
  assign bus.n_ALE      = n_ale_q;
  assign bus.RD         = rd_q;
  assign bus.WR         = wr_q;
  assign bus.CPU_DO     = cpu_do_q;
  assign bus.CPU_DO_VLD = vld_q;
  assign bus.BUSY       = busy_q;
  assign bus.DROP       = drop_q;

endmodule

// File: tb/tb_vram_access_ctrl.sv
// Bench for vram_access_ctrl: directed vector table, multi-cycle corner sequences and
// randomized single accesses checked against an address/buffer reference model.
module tb_vram_access_ctrl;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;

  logic PCLK = 1'b0;
  logic RES  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  vram_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  vram_access_ctrl #(
    .AW       (AW),
    .DW       (DW),
    .PAL_BASE (32'h3F00),
    .INC_WIDE (32)
  ) dut (
    .PCLK (PCLK),
    .RES  (RES),
    .bus  (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          ale_c;
    logic [13:0] pa;
    int          nale;
    int          str_c;
    int          nrd;
    int          nwr;
    logic [7:0]  pdo;
    int          vld_c;
    int          nvld;
    logic [7:0]  dout;
    int          ndrop;
    int          drop_c;
    int          clash;
    logic        busy1;
    logic        busy_end;
  } obs_t;

  typedef struct {
    logic [13:0] ld;
    logic        wr;
    logic [7:0]  d;
    logic        inc;
    logic [7:0]  pd;
    logic [13:0] exp_pa;
    logic        pal;
    logic [7:0]  exp_do;
    logic [13:0] exp_next;
  } vec_t;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_addr(input logic [13:0] a);
    bus.ADDR_LD = 1'b1;
    bus.ADDR_IN = a;
    tick();
    bus.ADDR_LD = 1'b0;
  endtask

  // Ticks n cycles after a request was driven; request lines drop after the first edge and
  // I_INC / CPU_DI are scrambled so only their request-time values may matter.
  task automatic observe(input int n, output obs_t o);
    o.ale_c = 0; o.pa = '0; o.nale = 0; o.str_c = 0; o.nrd = 0; o.nwr = 0; o.pdo = '0;
    o.vld_c = 0; o.nvld = 0; o.dout = '0; o.ndrop = 0; o.drop_c = 0; o.clash = 0;
    o.busy1 = 1'b0; o.busy_end = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      bus.W7     = 1'b0;
      bus.R7     = 1'b0;
      bus.I_INC  = ~bus.I_INC;
      bus.CPU_DI = ~bus.CPU_DI;
      if (k == 1) o.busy1 = bus.BUSY;
      if (!bus.n_ALE) begin
        o.nale++;
        if (o.ale_c == 0) begin o.ale_c = k; o.pa = bus.PA; end
      end
      if (bus.RD) begin o.nrd++; o.str_c = k; end
      if (bus.WR) begin o.nwr++; o.str_c = k; o.pdo = bus.PD_OUT; end
      if (bus.RD && bus.WR) o.clash++;
      if (bus.PD_OE != bus.WR) o.clash++;
      if (bus.CPU_DO_VLD) begin o.nvld++; o.vld_c = k; o.dout = bus.CPU_DO; end
      if (bus.DROP) begin o.ndrop++; o.drop_c = k; end
    end
    o.busy_end = bus.BUSY;
  endtask

  task automatic run_access(input logic wr, input logic [7:0] d, input logic inc,
                            input logic [7:0] pd, output obs_t o);
    bus.W7     = wr;
    bus.R7     = ~wr;
    bus.CPU_DI = d;
    bus.I_INC  = inc;
    bus.PD_IN  = pd;
    observe(8, o);
  endtask

  task automatic verify(input string tag, input obs_t o, input logic wr, input logic [13:0] exp_pa,
                        input logic [7:0] exp_d, input logic pal, input logic [7:0] exp_do,
                        input logic [13:0] exp_next);
    check($sformatf("%s.ale_cycle", tag), o.ale_c, 1);
    check($sformatf("%s.ale_count", tag), o.nale, 1);
    check($sformatf("%s.pa", tag), 32'(o.pa), 32'(exp_pa));
    check($sformatf("%s.strobe_cycle", tag), o.str_c, 2);
    check($sformatf("%s.wr_pulses", tag), o.nwr, wr ? 1 : 0);
    check($sformatf("%s.rd_pulses", tag), o.nrd, wr ? 0 : 1);
    check($sformatf("%s.strobe_clash", tag), o.clash, 0);
    check($sformatf("%s.busy_start", tag), 32'(o.busy1), 32'd1);
    check($sformatf("%s.busy_end", tag), 32'(o.busy_end), 32'd0);
    if (wr) begin
      check($sformatf("%s.pd_out", tag), 32'(o.pdo), 32'(exp_d));
      check($sformatf("%s.vld_count", tag), o.nvld, 0);
    end else begin
      check($sformatf("%s.vld_count", tag), o.nvld, 1);
      check($sformatf("%s.vld_cycle", tag), o.vld_c, pal ? 4 : 1);
      check($sformatf("%s.cpu_do", tag), 32'(o.dout), 32'(exp_do));
    end
    check($sformatf("%s.next_addr", tag), 32'(dut.u_addr.addr_q), 32'(exp_next));
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.pa", tag), 32'(bus.PA), 32'd0);
    check($sformatf("%s.n_ale", tag), 32'(bus.n_ALE), 32'd1);
    check($sformatf("%s.rd", tag), 32'(bus.RD), 32'd0);
    check($sformatf("%s.wr", tag), 32'(bus.WR), 32'd0);
    check($sformatf("%s.pd_oe", tag), 32'(bus.PD_OE), 32'd0);
    check($sformatf("%s.cpu_do", tag), 32'(bus.CPU_DO), 32'd0);
    check($sformatf("%s.vld", tag), 32'(bus.CPU_DO_VLD), 32'd0);
    check($sformatf("%s.busy", tag), 32'(bus.BUSY), 32'd0);
    check($sformatf("%s.drop", tag), 32'(bus.DROP), 32'd0);
    check($sformatf("%s.addr", tag), 32'(dut.u_addr.addr_q), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    obs_t        o;
    logic [13:0] m_addr;
    logic [7:0]  m_buf;
    logic [13:0] a;
    logic [13:0] nxt;
    logic        rw;
    logic        inc;
    logic        pal;
    logic [7:0]  d;
    logic [7:0]  pd;
    int          wr_c[2];
    logic [7:0]  wr_d[2];
    logic [13:0] pa2;
    int          nw;
    int          nd;
    int          drop_c;
    int          waits;

    vecs[0] = '{14'h2000, 1'b1, 8'h5A, 1'b0, 8'h00, 14'h2000, 1'b0, 8'h00, 14'h2001};
    vecs[1] = '{14'h2400, 1'b0, 8'h00, 1'b0, 8'h11, 14'h2400, 1'b0, 8'h00, 14'h2401};
    vecs[2] = '{14'h2400, 1'b0, 8'h00, 1'b0, 8'h22, 14'h2400, 1'b0, 8'h11, 14'h2401};
    vecs[3] = '{14'h3F05, 1'b0, 8'h00, 1'b0, 8'h0C, 14'h3F05, 1'b1, 8'h0C, 14'h3F06};
    vecs[4] = '{14'h3FE8, 1'b1, 8'h77, 1'b1, 8'h00, 14'h3FE8, 1'b0, 8'h00, 14'h0008};
    vecs[5] = '{14'h3EFF, 1'b0, 8'h00, 1'b1, 8'h99, 14'h3EFF, 1'b0, 8'h0C, 14'h3F1F};
    vecs[6] = '{14'h3FFF, 1'b0, 8'h00, 1'b0, 8'h44, 14'h3FFF, 1'b1, 8'h44, 14'h0000};
    vecs[7] = '{14'h3F00, 1'b0, 8'h00, 1'b0, 8'h55, 14'h3F00, 1'b1, 8'h55, 14'h3F01};
    vecs[8] = '{14'h0000, 1'b1, 8'hA5, 1'b1, 8'h00, 14'h0000, 1'b0, 8'h00, 14'h0020};

    bus.BLNK = 1'b1; bus.R7 = 1'b0; bus.W7 = 1'b0; bus.CPU_DI = '0; bus.I_INC = 1'b0;
    bus.ADDR_LD = 1'b0; bus.ADDR_IN = '0; bus.PD_IN = '0;
    RES = 1'b1;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    RES = 1'b0;
    tick();

    m_addr = '0;
    m_buf  = '0;
    foreach (vecs[i]) begin
      load_addr(vecs[i].ld);
      run_access(vecs[i].wr, vecs[i].d, vecs[i].inc, vecs[i].pd, o);
      verify($sformatf("vec%0d", i), o, vecs[i].wr, vecs[i].exp_pa, vecs[i].d, vecs[i].pal,
             vecs[i].exp_do, vecs[i].exp_next);
      if (!vecs[i].wr) m_buf = vecs[i].pd;
    end

    // Three back-to-back writes: second queued, third dropped.
    load_addr(14'h1000);
    nw = 0; nd = 0; drop_c = 0; pa2 = '0; wr_c = '{0, 0}; wr_d = '{8'h00, 8'h00};
    bus.I_INC = 1'b0;
    for (int k = 0; k < 14; k++) begin
      bus.W7     = (k < 3);
      bus.CPU_DI = 8'(k + 1);
      tick();
      if (bus.WR) begin
        if (nw < 2) begin wr_c[nw] = k + 1; wr_d[nw] = bus.PD_OUT; end
        nw++;
      end
      if (bus.DROP) begin nd++; drop_c = k + 1; end
      if (!bus.n_ALE && k >= 2) pa2 = bus.PA;
    end
    bus.W7 = 1'b0;
    check("b2b.wr_pulses", nw, 2);
    check("b2b.drop_pulses", nd, 1);
    check("b2b.drop_cycle", drop_c, 3);
    check("b2b.wr1_cycle", wr_c[0], 2);
    check("b2b.wr2_cycle", wr_c[1], 5);
    check("b2b.wr1_data", 32'(wr_d[0]), 32'h01);
    check("b2b.wr2_data", 32'(wr_d[1]), 32'h02);
    check("b2b.pa2", 32'(pa2), 32'h1001);
    check("b2b.next_addr", 32'(dut.u_addr.addr_q), 32'h1002);
    check("b2b.busy_end", 32'(bus.BUSY), 32'd0);

    // R7 and W7 together: the write is performed, the read dropped.
    load_addr(14'h0300);
    bus.R7 = 1'b1; bus.W7 = 1'b1; bus.CPU_DI = 8'h3C; bus.I_INC = 1'b0;
    observe(8, o);
    check("both.drop_count", o.ndrop, 1);
    check("both.drop_cycle", o.drop_c, 1);
    verify("both", o, 1'b1, 14'h0300, 8'h3C, 1'b0, 8'h00, 14'h0301);

    // Rendering active: request waits with BUSY high, then runs once BLNK rises.
    load_addr(14'h0100);
    bus.BLNK = 1'b0;
    bus.W7 = 1'b1; bus.CPU_DI = 8'h66; bus.I_INC = 1'b0;
    tick();
    bus.W7 = 1'b0; bus.CPU_DI = 8'h00; bus.I_INC = 1'b1;
    waits = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.BUSY && bus.n_ALE && !bus.WR) waits++;
      tick();
    end
    check("blnk.wait_cycles", waits, 4);
    bus.BLNK = 1'b1;
    bus.CPU_DI = 8'h00;
    observe(8, o);
    verify("blnk", o, 1'b1, 14'h0100, 8'h66, 1'b0, 8'h00, 14'h0101);

    // ADDR_LD during STROBE and during DONE: in-flight PA holds, load beats increment.
    load_addr(14'h0500);
    bus.W7 = 1'b1; bus.CPU_DI = 8'h12; bus.I_INC = 1'b0;
    tick();
    bus.W7 = 1'b0;
    tick();
    bus.ADDR_LD = 1'b1; bus.ADDR_IN = 14'h0ABC;
    tick();
    check("ld.pa_in_done", 32'(bus.PA), 32'h0500);
    check("ld.addr_after_strobe_load", 32'(dut.u_addr.addr_q), 32'h0ABC);
    bus.ADDR_IN = 14'h0777;
    tick();
    bus.ADDR_LD = 1'b0;
    check("ld.addr_over_increment", 32'(dut.u_addr.addr_q), 32'h0777);
    tick(); tick();

    // Randomized single accesses against the address/buffer model.
    for (int i = 0; i < 120; i++) begin
      if (i == 0 || $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       a = 14'($urandom_range(32'h3EF0, 32'h3FFF));
          1:       a = 14'($urandom_range(32'h3FD0, 32'h3FFF));
          default: a = 14'($urandom);
        endcase
        load_addr(a);
        m_addr = a;
      end
      rw  = 1'($urandom);
      inc = 1'($urandom);
      d   = 8'($urandom);
      pd  = 8'($urandom);
      pal = (m_addr >= 14'h3F00);
      nxt = 14'(32'(m_addr) + (inc ? 32 : 1));
      run_access(rw, d, inc, pd, o);
      verify($sformatf("rnd%0d", i), o, rw, m_addr, d, pal, pal ? pd : m_buf, nxt);
      if (!rw) m_buf = pd;
      m_addr = nxt;
    end

    // Reset during STROBE aborts the access; the buffer is cleared too.
    load_addr(14'h0400);
    run_access(1'b0, 8'h00, 1'b0, 8'hE7, o);
    verify("preload", o, 1'b0, 14'h0400, 8'h00, 1'b0, m_buf, 14'h0401);
    load_addr(14'h3F10);
    bus.R7 = 1'b1; bus.PD_IN = 8'h81; bus.I_INC = 1'b0;
    tick();
    bus.R7 = 1'b0;
    tick();
    check("abort.rd_before_reset", 32'(bus.RD), 32'd1);
    RES = 1'b1;
    tick();
    RES = 1'b0;
    check_reset_outputs("abort");
    observe(6, o);
    check("abort.late_vld", o.nvld, 0);
    check("abort.late_ale", o.nale, 0);
    check("abort.late_rd", o.nrd, 0);
    run_access(1'b0, 8'h00, 1'b0, 8'h3B, o);
    verify("post_abort", o, 1'b0, 14'h0000, 8'h00, 1'b0, 8'h00, 14'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
